shifter_seq: RTL and testbench

//   Multi-cycle parametrised shift unit for the URCPU datapath; successor to the combinational right shifter.

---
 rtl/shifter_seq_if.sv | 29 ++
 rtl/shifter_seq.sv | 118 +++++++++++
 tb/tb_shifter_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_seq_if.sv
// Handshake bundle for the multi-cycle shift unit: operation request side and result side.
// The master is the execute stage that issues operations; the slave is the shift unit.
interface shifter_seq_if #(
  parameter int DATA_WIDTH  = 20,
  parameter int SHAMT_WIDTH = 5
);
  // valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
  // the producer holds valid and its payload stable until that edge, and ready may not depend
  // combinationally on valid.
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [SHAMT_WIDTH-1:0] shift_amount;
  logic [1:0]             mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   busy;

  modport master (
    output in_valid, data_in, shift_amount, mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, shift_amount, mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shift unit (SRL/SRA/SLL/ROR), shifting up to STEP bits per cycle.
// One operation in flight; the result is held until the consumer takes it.
module shifter_seq #(
  parameter int DATA_WIDTH  = 20,
  parameter int SHAMT_WIDTH = 5,
  parameter int STEP        = 4
) (
  input  logic         clk,
  input  logic         rst,
  shifter_seq_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_SRL = 2'b00;
  localparam logic [1:0] M_SRA = 2'b01;
  localparam logic [1:0] M_SLL = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [SHAMT_WIDTH-1:0] STEP_S = SHAMT_WIDTH'(STEP);
  localparam logic [SHAMT_WIDTH-1:0] DW_S   = SHAMT_WIDTH'(DATA_WIDTH);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  work;
  logic [1:0]             mode_q;
  logic                   sign_q;
  logic [SHAMT_WIDTH-1:0] rem;

  logic [SHAMT_WIDTH-1:0] n_eff;
  logic [SHAMT_WIDTH-1:0] k;
  logic [DATA_WIDTH-1:0]  fill_mask;
  logic [DATA_WIDTH-1:0]  step_res;

  assign state_dbg = state;

  // Rotation keeps the full count, so only the non-rotating modes saturate at the width.
  always_comb begin
    n_eff = bus.shift_amount;
    if (bus.mode != M_ROR && bus.shift_amount > DW_S)
      n_eff = DW_S;
  end

  always_comb begin
    k         = (rem > STEP_S) ? STEP_S : rem;
    fill_mask = ~({DATA_WIDTH{1'b1}} >> k);
    step_res  = work;
    case (mode_q)
      M_SRL:   step_res = work >> k;
      M_SRA:   step_res = (work >> k) | (fill_mask & {DATA_WIDTH{sign_q}});
      M_SLL:   step_res = work << k;
      M_ROR:   step_res = (work >> k) | (work << (DW_S - k));
      default: step_res = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      work         <= '0;
      mode_q       <= M_SRL;
      sign_q       <= 1'b0;
      rem          <= '0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            work         <= bus.data_in;
            mode_q       <= bus.mode;
            sign_q       <= bus.data_in[DATA_WIDTH-1];
            rem          <= n_eff;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (n_eff == '0) begin
              state         <= S_DONE;
              bus.out_valid <= 1'b1;
              bus.data_out  <= bus.data_in;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= step_res;
          rem  <= rem - k;
          if (rem == k) begin
            state         <= S_DONE;
            bus.out_valid <= 1'b1;
            bus.data_out  <= step_res;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq: shift modes, saturation, rotation, backpressure and reset abort.
module tb_shifter_seq;

  localparam int DW = 20;
  localparam int SW = 5;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         pass_cnt;
  int         total_cnt;

  shifter_seq_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

  shifter_seq #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one operation with out_ready high; lat counts rising edges from the accept edge
  // up to the first edge after which out_valid is seen high (-1 if never).
  task automatic run_op(input logic [DW-1:0] d, input logic [SW-1:0] amt, input logic [1:0] m,
                        output logic [DW-1:0] res, output int lat);
    int waited;
    waited = 0;
    lat = -1;
    res = 'x;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    bus.data_in      = d;
    bus.shift_amount = amt;
    bus.mode         = m;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = e;
        res = bus.data_out;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 20'h00000) $display("FAIL reset_data_out got %h want 00000", bus.data_out); else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d want 0", state_dbg); else pass_cnt++;
  endtask

  task automatic test_basic_modes();
    logic [DW-1:0] res;
    int lat;
    run_op(20'hAAAAA, 5'd3, 2'b00, res, lat);
    total_cnt++;
    if (res !== 20'h15555) $display("FAIL srl3_data got %h want 15555", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL srl3_latency got %0d want 2", lat); else pass_cnt++;
    run_op(20'h8A8AA, 5'd7, 2'b01, res, lat);
    total_cnt++;
    if (res !== 20'hFF151) $display("FAIL sra7_data got %h want FF151", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL sra7_latency got %0d want 3", lat); else pass_cnt++;
    run_op(20'h00001, 5'd7, 2'b10, res, lat);
    total_cnt++;
    if (res !== 20'h00080) $display("FAIL sll7_data got %h want 00080", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 3) $display("FAIL sll7_latency got %0d want 3", lat); else pass_cnt++;
  endtask

  task automatic test_large_amount();
    logic [DW-1:0] res;
    int lat;
    run_op(20'h80000, 5'd25, 2'b01, res, lat);
    total_cnt++;
    if (res !== 20'hFFFFF) $display("FAIL sra25_data got %h want FFFFF", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 6) $display("FAIL sra25_latency got %0d want 6", lat); else pass_cnt++;
    run_op(20'h80000, 5'd25, 2'b00, res, lat);
    total_cnt++;
    if (res !== 20'h00000) $display("FAIL srl25_data got %h want 00000", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 6) $display("FAIL srl25_latency got %0d want 6", lat); else pass_cnt++;
    run_op(20'h80000, 5'd25, 2'b10, res, lat);
    total_cnt++;
    if (res !== 20'h00000) $display("FAIL sll25_data got %h want 00000", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 6) $display("FAIL sll25_latency got %0d want 6", lat); else pass_cnt++;
  endtask

  task automatic test_rotate();
    logic [DW-1:0] res;
    int lat;
    run_op(20'h00001, 5'd4, 2'b11, res, lat);
    total_cnt++;
    if (res !== 20'h10000) $display("FAIL ror4_data got %h want 10000", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL ror4_latency got %0d want 2", lat); else pass_cnt++;
    run_op(20'h00001, 5'd0, 2'b11, res, lat);
    total_cnt++;
    if (res !== 20'h00001) $display("FAIL ror0_data got %h want 00001", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 1) $display("FAIL ror0_latency got %0d want 1", lat); else pass_cnt++;
    run_op(20'h00001, 5'd24, 2'b11, res, lat);
    total_cnt++;
    if (res !== 20'h10000) $display("FAIL ror24_data got %h want 10000", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 7) $display("FAIL ror24_latency got %0d want 7", lat); else pass_cnt++;
    run_op(20'h12345, 5'd20, 2'b11, res, lat);
    total_cnt++;
    if (res !== 20'h12345) $display("FAIL ror20_data got %h want 12345", res); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int seen;
    int bad;
    seen = 0;
    bad  = 0;
    @(negedge clk);
    bus.data_in      = 20'hAAAAA;
    bus.shift_amount = 5'd3;
    bus.mode         = 2'b00;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b0;
    @(posedge clk);
    #1;
    // A different operation stays offered while the unit is busy and must be ignored.
    bus.data_in      = 20'h00001;
    bus.shift_amount = 5'd1;
    bus.mode         = 2'b10;
    for (int e = 0; e < 20 && seen == 0; e++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    total_cnt++;
    if (seen !== 1) $display("FAIL bp_out_valid_seen got %0d want 1", seen); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.data_out !== 20'h15555 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
        bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0 (data_out %h)", bad, bus.data_out); else pass_cnt++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] res;
    int lat;
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.data_in      = 20'hFFFFF;
    bus.shift_amount = 5'd20;
    bus.mode         = 2'b00;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++;
    if (bus.data_out !== 20'h00000) $display("FAIL abort_data_out got %h want 00000", bus.data_out); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL abort_no_pulse got %0d pulses want 0", pulses); else pass_cnt++;
    run_op(20'h00002, 5'd1, 2'b00, res, lat);
    total_cnt++;
    if (res !== 20'h00001) $display("FAIL post_abort_data got %h want 00001", res); else pass_cnt++;
    total_cnt++;
    if (lat !== 2) $display("FAIL post_abort_latency got %0d want 2", lat); else pass_cnt++;
  endtask

  task automatic test_reset_wins();
    @(negedge clk);
    bus.data_in      = 20'h0000F;
    bus.shift_amount = 5'd2;
    bus.mode         = 2'b00;
    bus.in_valid     = 1'b1;
    rst              = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rst_wins_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_wins_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.data_in      = '0;
    bus.shift_amount = '0;
    bus.mode         = 2'b00;
    bus.out_ready    = 1'b1;
    test_reset();
    test_basic_modes();
    test_large_amount();
    test_rotate();
    test_backpressure();
    test_reset_abort();
    test_reset_wins();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
